// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, widths, default reset PC.
// Used by pc_fetch_unit and its optional stall counter (FETCH_PERF_EN).
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  // Word-address increment; wraps modulo 2^32 by construction.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter, one-cycle update, cleared only by synchronous reset.
// No backpressure: counts every cycle inc is high until it pins at all-ones.
module fetch_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch sequencer: one outstanding imem request, bundle to decode the edge after the response; holds it while if_ready is low.
// Redirect overrides every transition. FETCH_PERF_EN adds the stall_count port (saturating decode-stall counter).
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_npc,
  input  logic               if_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, req_pc;
  logic            req_fire, capture, release_bundle;

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    capture        = 1'b0;
    release_bundle = 1'b0;
    case (state)
      REQ:  if (req_fire) begin
              pc_nxt    = pc_inc(pc);
              state_nxt = WAIT;
            end
      WAIT: if (imem_rsp_valid) begin
              capture   = 1'b1;
              state_nxt = HOLD;
            end
      HOLD: if (if_ready) begin
              release_bundle = 1'b1;
              state_nxt      = REQ;
            end
      DROP: if (imem_rsp_valid) state_nxt = REQ;
    endcase

    // A redirect kills whatever is in flight; a request accepted this cycle still owes a response.
    if (redirect_valid) begin
      pc_nxt  = redirect_pc;
      capture = 1'b0;
      case (state)
        REQ:  state_nxt = req_fire ? DROP : REQ;
        WAIT: state_nxt = imem_rsp_valid ? REQ : DROP;
        HOLD: begin
                release_bundle = 1'b1;
                state_nxt      = REQ;
              end
        DROP: state_nxt = imem_rsp_valid ? REQ : DROP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      if_npc   <= '0;
    end else begin
      pc <= pc_nxt;
      if (req_fire) req_pc <= pc;
      if (capture) begin
        if_valid <= 1'b1;
        if_instr <= imem_rsp_data;
        if_pc    <= req_pc;
        if_npc   <= pc_inc(req_pc);
      end else if (release_bundle) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counter #(.W(32)) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (if_valid && !if_ready && !redirect_valid),
    .count (stall_count)
  );
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model (outstanding request / displayed bundle).
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        if_valid, if_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, if_instr, if_pc, if_npc;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_count;
`endif

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .if_ready       (if_ready)
`ifdef FETCH_PERF_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Behavioural model: one outstanding request, one displayed bundle.
  bit          m_init = 1'b0;
  bit          m_out, m_live, m_bv;
  logic [31:0] m_pc, m_opc, m_bi, m_bp, m_bn, m_stall;
  bit          fire, got, stall_ev;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_out = 1'b0; m_live = 1'b0; m_bv = 1'b0;
      m_pc = RPC; m_opc = '0; m_bi = '0; m_bp = '0; m_bn = '0; m_stall = '0;
    end else if (m_init) begin
      fire     = !m_out && !m_bv && imem_req_ready;
      got      = m_out && imem_rsp_valid;
      stall_ev = m_bv && !if_ready && !redirect_valid;
      if (stall_ev && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (redirect_valid) begin
        if (got) m_out = 1'b0;
        else if (m_out) m_live = 1'b0;
        if (fire) begin m_out = 1'b1; m_live = 1'b0; end
        m_bv = 1'b0;
        m_pc = redirect_pc;
      end else if (fire) begin
        m_out = 1'b1; m_live = 1'b1; m_opc = m_pc; m_pc = m_pc + 1;
      end else if (got) begin
        m_out = 1'b0;
        if (m_live) begin
          m_bv = 1'b1; m_bi = imem_rsp_data; m_bp = m_opc; m_bn = m_opc + 1;
        end
      end else if (m_bv && if_ready) begin
        m_bv = 1'b0;
      end
    end
    #2;
    if (m_init) begin
      chk1("m_req_valid", imem_req_valid, !rst && !m_out && !m_bv);
      if (!rst && !m_out && !m_bv) chk("m_req_addr", imem_req_addr, m_pc);
      chk1("m_if_valid", if_valid, m_bv);
      chk("m_if_instr", if_instr, m_bi);
      chk("m_if_pc", if_pc, m_bp);
      chk("m_if_npc", if_npc, m_bn);
`ifdef FETCH_PERF_EN
      chk("m_stall_count", stall_count, m_stall);
`endif
    end
  end

  // Stimulus state and memory responder.
  bit          g_rst, g_rr, g_ifr, g_rdv, g_frs, rand_lat;
  logic [31:0] g_rpc;
  int          lat = 1;
  bit          hs = 1'b0;
  logic [31:0] haddr;
  logic [31:0] hs_q[$];
  bit          pend = 1'b0;
  int          cnt;
  logic [31:0] paddr;
  logic [31:0] watch_pc = 32'hFFFF_FFF0;
  bit          seen_watch = 1'b0;

  task automatic cyc();
    @(negedge clk);
    if (hs) begin
      pend  = 1'b1;
      cnt   = (rand_lat ? int'($urandom_range(1, 3)) : lat) - 1;
      paddr = haddr;
    end
    if (g_frs) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    end else if (pend && cnt == 0) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(paddr); pend = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      if (pend) cnt--;
    end
    rst            = g_rst;
    imem_req_ready = g_rr;
    if_ready       = g_ifr;
    redirect_valid = g_rdv;
    redirect_pc    = g_rdv ? g_rpc : $urandom;
    g_rdv = 1'b0;
    g_frs = 1'b0;
    #1;
    hs    = imem_req_valid && imem_req_ready;
    haddr = imem_req_addr;
    if (hs) hs_q.push_back(haddr);
    if (if_valid && (if_pc == watch_pc)) seen_watch = 1'b1;
  endtask

  task automatic wait_hs(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc();
      ok = hs;
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_ifv(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc();
      ok = if_valid;
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    bit found;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    g_rst = 1'b1; g_rr = 1'b0; g_ifr = 1'b0; g_rdv = 1'b0; g_frs = 1'b0; g_rpc = '0; rand_lat = 1'b0;
    cyc(); cyc();

    // Reset values, first-fetch timing, sequential addresses.
    g_rst = 1'b0; g_rr = 1'b1; g_ifr = 1'b1; lat = 1;
    cyc();
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_npc", if_npc, 32'h0);
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_EN
    chk("rst_stall_count", stall_count, 32'h0);
`endif
    cyc();
    chk1("t1_if_valid_c1", if_valid, 1'b0);
    cyc();
    chk1("t1_if_valid_c2", if_valid, 1'b1);
    chk("t1_if_pc", if_pc, 32'h100);
    chk("t1_if_npc", if_npc, 32'h101);
    chk("t1_if_instr", if_instr, mem_word(32'h100));
    for (int i = 0; i < 30 && hs_q.size() < 3; i++) cyc();
    if (hs_q.size() < 3) timeout("t1_three_reqs");
    else begin
      chk("t1_req0", hs_q[0], 32'h100);
      chk("t1_req1", hs_q[1], 32'h101);
      chk("t1_req2", hs_q[2], 32'h102);
    end

    // Redirect while the response for 0x105 is pending.
    lat = 3; found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      cyc();
      found = hs && (haddr == 32'h105);
    end
    if (!found) timeout("t2_reach_105");
    watch_pc = 32'h105; seen_watch = 1'b0;
    g_rdv = 1'b1; g_rpc = 32'h40;
    cyc();
    chk1("t2_no_req_in_wait", imem_req_valid, 1'b0);
    wait_hs("t2_refetch");
    chk("t2_next_req", haddr, 32'h40);
    wait_ifv("t2_bundle");
    chk("t2_if_pc", if_pc, 32'h40);
    chk("t2_if_instr", if_instr, mem_word(32'h40));
    chk1("t2_no_105_bundle", seen_watch, 1'b0);

    // Decode stall for 5 cycles on the 0x41 bundle.
    lat = 1; g_ifr = 1'b0;
    wait_ifv("t3_bundle");
    for (int k = 1; k < 5; k++) begin
      cyc();
      chk("t3_pc_hold", if_pc, 32'h41);
      chk("t3_instr_hold", if_instr, mem_word(32'h41));
      chk1("t3_no_req", imem_req_valid, 1'b0);
    end
    g_ifr = 1'b1;
    cyc();
    chk1("t3_valid_kept", if_valid, 1'b1);
`ifdef FETCH_PERF_EN
    chk("t3_stall_count", stall_count, 32'd5);
`endif

    // Wrap at the top of the address space.
    g_rdv = 1'b1; g_rpc = 32'hFFFF_FFFF;
    cyc();
    wait_hs("t4_req_wrap");
    chk("t4_req_ffff", haddr, 32'hFFFF_FFFF);
    wait_ifv("t4_bundle");
    chk("t4_if_pc", if_pc, 32'hFFFF_FFFF);
    chk("t4_if_npc", if_npc, 32'h0);
    chk("t4_if_instr", if_instr, mem_word(32'hFFFF_FFFF));
    wait_hs("t4_req_after_wrap");
    chk("t4_req_zero", haddr, 32'h0);

    // Memory not ready for 4 cycles, then redirect on the accepting edge.
    lat = 2; g_rr = 1'b0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      found = imem_req_valid;
    end
    if (!found) timeout("t5_req_valid");
    chk("t5_addr_0", imem_req_addr, 32'h1);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk1("t5_valid_held", imem_req_valid, 1'b1);
      chk("t5_addr_held", imem_req_addr, 32'h1);
    end
    watch_pc = 32'h1; seen_watch = 1'b0;
    g_rr = 1'b1; g_rdv = 1'b1; g_rpc = 32'h200;
    cyc();
    chk1("t5_hs_with_redirect", hs, 1'b1);
    wait_hs("t5_refetch");
    chk("t5_next_req", haddr, 32'h200);
    wait_ifv("t5_bundle");
    chk("t5_if_pc", if_pc, 32'h200);
    chk1("t5_dropped_bundle", seen_watch, 1'b0);

    // Reset while holding a bundle, then a stale response.
    g_ifr = 1'b0;
    wait_ifv("t6_bundle");
    chk("t6_if_pc", if_pc, 32'h201);
    g_rst = 1'b1;
    cyc();
    chk1("t6_req_valid_in_rst", imem_req_valid, 1'b0);
    cyc();
    chk1("t6_if_valid", if_valid, 1'b0);
    chk("t6_if_pc", if_pc, 32'h0);
    chk("t6_pc", imem_req_addr, RPC);
    chk1("t6_req_valid_rst_hi", imem_req_valid, 1'b0);
    g_rst = 1'b0; g_rr = 1'b0; g_frs = 1'b1;
    cyc();
    chk1("t6_req_after_rst", imem_req_valid, 1'b1);
    cyc();
    chk1("t6_stale_ignored", if_valid, 1'b0);
    chk("t6_addr_after_stale", imem_req_addr, RPC);

    // Randomized traffic against the model.
    rand_lat = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      g_rst = ($urandom_range(0, 149) == 0);
      g_rr  = ($urandom_range(0, 3) != 0);
      g_ifr = ($urandom_range(0, 9) < 7);
      g_rdv = ($urandom_range(0, 11) == 0);
      g_rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + $urandom_range(0, 2) : $urandom;
      cyc();
    end
    g_rst = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Fetch-stage sequencer that owns the program counter.
- Issues word-addressed instruction-memory requests over a valid/ready handshake and captures the returned instruction.
- Presents {instr, pc, pc+1} to decode with a valid/ready handshake.
- Sits between the branch/jump resolution path (redirect input) and decode; it produces the sequential next-PC that downstream stages consume.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  taken branch/jump from execute; highest priority
- redirect_pc  in  32  redirect target (word address)
- imem_req_valid  out  1  instruction fetch request
- imem_req_addr  out  32  fetch address (= current pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after accept)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  instruction bundle valid to decode
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- if_npc  out  32  if_pc + 1
- if_ready  in  1  decode accepts bundle
- stall_count  out  32  only when FETCH_PERF_EN defined

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset state is REQ.
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_npc=0, stall_count=0.
- While rst is high, imem_req_valid=0.
- imem_req_valid = (state==REQ) & ~rst; imem_req_addr = pc (combinational from registers).
- REQ: on req handshake → latch req_pc=pc, pc←pc+1, go to WAIT.
- WAIT: on imem_rsp_valid → if_instr←data, if_pc←req_pc, if_npc←req_pc+1, if_valid←1, go to HOLD.
- HOLD: outputs stable while if_valid & ~if_ready. On if_ready → if_valid←0, go to REQ.
- Redirect overrides all other transitions in its cycle:
  - Always: pc←redirect_pc.
  - In REQ: handshake in the same cycle → DROP; no handshake → stay in REQ.
  - In WAIT: → DROP; rsp_valid in the same cycle → discard the data and go to REQ.
  - In HOLD: if_valid←0 and the bundle is discarded, even if if_ready is high; → REQ.
  - In DROP: stay in DROP; rsp_valid in the same cycle → REQ.
- DROP: on imem_rsp_valid, discard the data and go to REQ.
- Arithmetic: 32-bit unsigned, modulo 2^32. pc=32'hFFFF_FFFF increments to 0. No fault is raised.
- Only one request is outstanding at any time. No request is issued in WAIT, HOLD or DROP.
- Reset mid-operation: state and outputs return to reset values on the next edge. Any response still in flight afterwards is ignored, because state is REQ and responses are only consumed in WAIT or DROP.

## Timing
- Request accepted at edge N; response at earliest N+1; if_valid high from edge N+2.
- Best-case throughput is one instruction per 3 cycles (REQ→WAIT→HOLD→REQ).
- Redirect at edge R with memory ready and no outstanding request: imem_req_addr=redirect_pc in cycle R+1.
- All outputs except imem_req_valid/imem_req_addr are registered.

## Configuration
- FETCH_PERF_EN defined:
  - stall_count increments each cycle with if_valid & ~if_ready & ~redirect_valid.
  - Saturates at 32'hFFFF_FFFF; cleared only by rst.
- FETCH_PERF_EN undefined: the stall_count port and its logic are absent.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t enum (REQ, WAIT, HOLD, DROP);
  - PC_W=32;
  - INSTR_W=32;
  - default RESET_PC constant.
- Optional sub-module fetch_perf_counter (saturating counter) is instantiated only under FETCH_PERF_EN.
- The PC register, FSM and +1 logic stay in the top module.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory, if_ready=1: requests to 0x100, 0x101, 0x102 in order. First bundle has if_pc=0x100, if_npc=0x101, and if_valid rises 2 cycles after the first accept.
- Redirect in WAIT to 0x40 while a response for 0x105 is pending: the 0x105 data never appears on if_*. The next request is 0x40; the bundle carries if_pc=0x40.
- Decode stall: hold if_ready=0 for 5 cycles in HOLD. if_instr/if_pc stay constant and no imem request is issued. With FETCH_PERF_EN, stall_count=5.
- Wrap: redirect to 32'hFFFF_FFFF. The bundle shows if_pc=FFFF_FFFF, if_npc=0, and the next request address is 0.
- imem_req_ready low for 4 cycles: imem_req_valid and imem_req_addr are held stable and pc does not advance. Redirect in the same cycle as the eventual handshake → DROP, the response is discarded, and the refetch goes to redirect_pc.
- Assert rst in HOLD: next cycle if_valid=0, pc=RESET_PC, imem_req_valid=0 while rst is high. A stale rsp_valid after reset is ignored.
